// File: rtl/inst_queue_pkg.sv
// Shared types and helpers for the fetch-to-decode instruction queue and the id decode lanes.
// MAX_LANES bounds the issue width the thermometer helper can describe.
package inst_queue_pkg;
  localparam int INST_W    = 32;
  localparam int PC_W      = 32;
  localparam int MAX_LANES = 2;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  function automatic entry_t pack_entry(input logic [INST_W-1:0] inst,
                                        input logic [PC_W-1:0]   pc);
    entry_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

  // Bit i set when more than i entries are available.
  function automatic logic [MAX_LANES-1:0] therm_mask(input int unsigned n);
    logic [MAX_LANES-1:0] m;
    for (int i = 0; i < MAX_LANES; i++) m[i] = (n > i);
    return m;
  endfunction
endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side push, decode-side present/pop and flush signals of the instruction queue.
// master drives pushes, pops and flushes; slave is the queue itself.
interface inst_queue_if #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   in_valid;
  logic [1:0]             in_cnt;
  logic [32*FETCH_W-1:0]  in_inst;
  logic [32*FETCH_W-1:0]  in_pc;
  logic                   in_ready;
  logic [ISSUE_W-1:0]     out_valid;
  logic [32*ISSUE_W-1:0]  out_inst;
  logic [32*ISSUE_W-1:0]  out_pc;
  logic [1:0]             out_pop;
  logic                   flush;
  logic                   flush_keep;
  logic                   ds_pending;
  logic [CW-1:0]          count;

  modport master (
    output in_valid, in_cnt, in_inst, in_pc, out_pop, flush, flush_keep,
    input  in_ready, out_valid, out_inst, out_pc, ds_pending, count
  );

  modport slave (
    input  in_valid, in_cnt, in_inst, in_pc, out_pop, flush, flush_keep,
    output in_ready, out_valid, out_inst, out_pc, ds_pending, count
  );
endinterface

// File: rtl/inst_queue_mem.sv
// iq_mem: DEPTH-entry {pc,inst} storage, FETCH_W synchronous write ports, ISSUE_W async read ports.
// Storage is not reset; validity is tracked entirely by the queue's pointers and count.
module iq_mem
  import inst_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                     clk,
  input  logic [FETCH_W-1:0]       we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i [FETCH_W],
  input  entry_t                   wdata_i [FETCH_W],
  input  logic [$clog2(DEPTH)-1:0] raddr_i [ISSUE_W],
  output entry_t                   rdata_o [ISSUE_W]
);
  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (we_i[i]) mem_q[waddr_i[i]] <= wdata_i[i];
    end
  end

  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) rdata_o[i] = mem_q[raddr_i[i]];
  end
endmodule

// File: rtl/inst_queue.sv
// In-order fetch->decode instruction queue with delay-slot-preserving branch flush.
// Push-to-present 1 cycle; in_ready from registered count only (needs FETCH_W free slots).
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input logic         clk,
  input logic         rst,
  inst_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ds_q, ds_d;

  logic          in_ready, push_acc, keep_lane0;
  logic [CW-1:0] push_n, pop_n, remain;

  logic [FETCH_W-1:0] wr_en;
  logic [AW-1:0]      waddr [FETCH_W];
  entry_t             wdata [FETCH_W];
  logic [AW-1:0]      raddr [ISSUE_W];
  entry_t             rdata [ISSUE_W];
  logic [MAX_LANES-1:0] vmask;

  assign in_ready   = (count_q <= CW'(DEPTH - FETCH_W));
  assign push_acc   = bus.in_valid && in_ready;
  assign pop_n      = CW'(bus.out_pop);
  assign remain     = count_q - pop_n;
  assign keep_lane0 = bus.flush && bus.flush_keep && (remain == '0);

  // An owed delay slot is the only instruction taken from the next push.
  always_comb begin
    push_n = '0;
    if (push_acc) push_n = ds_q ? CW'(1) : CW'(bus.in_cnt);
  end

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      waddr[i] = tail_q + AW'(i);
      wdata[i] = pack_entry(bus.in_inst[INST_W*i +: INST_W], bus.in_pc[PC_W*i +: PC_W]);
      wr_en[i] = (CW'(i) < push_n) && (!bus.flush || (keep_lane0 && i == 0));
    end
    for (int i = 0; i < ISSUE_W; i++) raddr[i] = head_q + AW'(i);
  end

  // The same-cycle pop is applied before any flush decision.
  always_comb begin
    head_d  = head_q + AW'(pop_n);
    tail_d  = tail_q + AW'(push_n);
    count_d = count_q + push_n - pop_n;
    ds_d    = ds_q && !push_acc;
    if (bus.flush) begin
      if (!bus.flush_keep) begin
        head_d  = tail_q;
        tail_d  = tail_q;
        count_d = '0;
        ds_d    = 1'b0;
      end else if (remain != '0) begin
        tail_d  = head_q + AW'(pop_n) + AW'(1);
        count_d = CW'(1);
        ds_d    = 1'b0;
      end else if (push_acc) begin
        head_d  = tail_q;
        tail_d  = tail_q + AW'(1);
        count_d = CW'(1);
        ds_d    = 1'b0;
      end else begin
        head_d  = tail_q;
        tail_d  = tail_q;
        count_d = '0;
        ds_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ds_q    <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ds_q    <= ds_d;
    end
  end

  iq_mem #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign vmask = therm_mask(32'(count_q));

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_out
    assign bus.out_valid[i]                  = vmask[i];
    assign bus.out_inst[INST_W*i +: INST_W] = rdata[i].inst;
    assign bus.out_pc[PC_W*i +: PC_W]       = rdata[i].pc;
  end

  assign bus.in_ready   = in_ready;
  assign bus.ds_pending = ds_q;
  assign bus.count      = count_q;

  a_pop_legal: assert property (@(posedge clk) disable iff (rst)
    int'(bus.out_pop) <= $countones(bus.out_valid));
  a_cnt_legal: assert property (@(posedge clk) disable iff (rst)
    bus.in_valid |-> (bus.in_cnt != 2'd0 && int'(bus.in_cnt) <= FETCH_W));
endmodule
